uart_readback: RTL and testbench

Transmit-side counterpart of the UART loader: on request, acquires one UART write-lock port and streams a header byte plus a run of memory words back to the host, least-significant byte first. Sits between a word-addressed memory read port (blockmem or imem) and one `write_lock_req/res` + `data_in/data_in_valid` lane of `uart_controller`. It provides host-side readback of loaded instructions and buffers, and liveness echo.

---
 rtl/uart_readback.sv | 101 ++++++++++
 tb/tb_uart_readback.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_readback.sv
// uart_readback: on request, takes the UART write lock and streams a header byte plus
// a run of memory words back to the host, least-significant byte first.
module uart_readback #(
    parameter int BITWIDTH = 32,
    parameter int LENWIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [1:0]          req_kind,
    input  logic [BITWIDTH-1:0] req_addr,
    input  logic [LENWIDTH-1:0] req_len,
    output logic                mem_read_valid,
    output logic [BITWIDTH-1:0] mem_read_addr,
    input  logic [BITWIDTH-1:0] mem_read_data,
    output logic                lock_req,
    input  logic                lock_res,
    input  logic                write_ready,
    output logic [7:0]          write_data,
    output logic                write_data_valid,
    output logic                done
);
    localparam int BYTES = BITWIDTH / 8;
    localparam int CW = BYTES > 1 ? $clog2(BYTES) : 1;

    typedef enum logic [2:0] {IDLE, LOCK, HEADER, FETCH, WAIT, SEND, RELEASE} state_t;

    state_t              state, next_state;
    logic [1:0]          kind;
    logic [LENWIDTH-1:0] words_left;
    logic [BITWIDTH-1:0] shift;
    logic [CW-1:0]       byte_ctr;
    logic                accept, handshake, last_byte;

    assign accept    = req_valid & req_ready;
    assign handshake = write_data_valid & write_ready;
    assign last_byte = byte_ctr == CW'(BYTES - 1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    next_state = accept ? LOCK : IDLE;
            LOCK:    next_state = lock_res ? HEADER : LOCK;
            HEADER:  next_state = !handshake ? HEADER : (words_left == '0 ? RELEASE : FETCH);
            FETCH:   next_state = WAIT;
            WAIT:    next_state = SEND;
            SEND:    next_state = !(handshake && last_byte) ? SEND
                                : (words_left == LENWIDTH'(1) ? RELEASE : FETCH);
            RELEASE: next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so each one lines up with its state.
    // mem_read_addr doubles as the running word address.
    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            req_ready        <= 1'b1;
            lock_req         <= 1'b0;
            mem_read_valid   <= 1'b0;
            mem_read_addr    <= '0;
            write_data       <= '0;
            write_data_valid <= 1'b0;
            done             <= 1'b0;
            kind             <= '0;
            words_left       <= '0;
            shift            <= '0;
            byte_ctr         <= '0;
        end else begin
            state            <= next_state;
            req_ready        <= next_state == IDLE;
            lock_req         <= next_state inside {LOCK, HEADER, FETCH, WAIT, SEND};
            mem_read_valid   <= next_state == FETCH;
            write_data_valid <= next_state inside {HEADER, SEND};
            done             <= next_state == RELEASE;
            if (accept) begin
                kind          <= req_kind;
                mem_read_addr <= req_addr;
                words_left    <= req_kind == 2'b00 ? '0 : req_len;
            end
            if (state == LOCK && lock_res)
                write_data <= {kind, 6'b0};
            if (state == WAIT) begin
                write_data <= mem_read_data[7:0];
                shift      <= mem_read_data >> 8;
                byte_ctr   <= '0;
            end
            if (state == SEND && handshake) begin
                write_data <= shift[7:0];
                shift      <= shift >> 8;
                byte_ctr   <= byte_ctr + CW'(1);
                if (last_byte) begin
                    mem_read_addr <= mem_read_addr + BITWIDTH'(1);
                    words_left    <= words_left - LENWIDTH'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_readback.sv
// tb_uart_readback: table-driven and randomized readback requests checked against a
// byte-stream model built from the request fields and a memory content function.
module tb_uart_readback;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_kind = '0;
    logic [31:0] req_addr = '0;
    logic [7:0]  req_len = '0;
    logic        mem_read_valid;
    logic [31:0] mem_read_addr;
    logic [31:0] mem_read_data = '0;
    logic        lock_req;
    logic        lock_res = 1'b0;
    logic        write_ready = 1'b1;
    logic [7:0]  write_data;
    logic        write_data_valid;
    logic        done;

    uart_readback dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_addr(req_addr), .req_len(req_len),
        .mem_read_valid(mem_read_valid), .mem_read_addr(mem_read_addr),
        .mem_read_data(mem_read_data),
        .lock_req(lock_req), .lock_res(lock_res),
        .write_ready(write_ready), .write_data(write_data),
        .write_data_valid(write_data_valid), .done(done)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    bit bp = 1'b0;

    logic [7:0]  bytes_q[$];
    int          hs_q[$];
    logic [31:0] reads_q[$];
    int          rd_q[$];
    int          done_cnt = 0;
    int          stall_err = 0;
    int          lock_err = 0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data = '0;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h10) return 32'h44332211;
        if (a == 32'h11) return 32'h88776655;
        return (a * 32'h9E3779B1) ^ 32'hA5C30F1E;
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // Memory answers exactly one cycle after the strobe; other cycles carry junk.
    always @(posedge clock)
        mem_read_data <= mem_read_valid ? mem_fn(mem_read_addr) : 32'hDEADBEEF;

    always @(posedge clock) begin
        #1;
        write_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clock) begin
        if (!reset) begin
            if (prev_stall && (!write_data_valid || write_data !== prev_data)) stall_err++;
            if (write_data_valid && !lock_req) lock_err++;
            if (write_data_valid && write_ready) begin
                bytes_q.push_back(write_data);
                hs_q.push_back(cyc);
            end
            if (mem_read_valid) begin
                reads_q.push_back(mem_read_addr);
                rd_q.push_back(cyc);
            end
            if (done) done_cnt++;
        end
        prev_stall = !reset && write_data_valid && !write_ready;
        prev_data  = write_data;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic [1:0] k, input logic [31:0] a, input logic [7:0] l,
                          input int gd, input bit bpm, input bit poke, output int b0);
        int r0, d0, s0, e0, t_g, t_d, bad, m, n;
        logic [7:0]  exp_b[$];
        logic [31:0] exp_r[$];
        logic [31:0] w;
        b0 = bytes_q.size(); r0 = reads_q.size(); d0 = done_cnt; s0 = stall_err; e0 = lock_err;
        n = (k == 2'b00) ? 0 : int'(l);
        exp_b.push_back({k, 6'b0});
        for (int i = 0; i < n; i++) begin
            exp_r.push_back(a + 32'(i));
            w = mem_fn(a + 32'(i));
            for (int j = 0; j < 4; j++) exp_b.push_back(w[8*j +: 8]);
        end
        bad = 0;
        while (!req_ready && bad < 50) begin tick(); bad++; end
        bp = bpm;
        req_valid = 1'b1; req_kind = k; req_addr = a; req_len = l;
        chk("req_ready idle", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("lock_req at t+1", lock_req, 1);
        chk("req_ready busy", req_ready, 0);
        bad = 0;
        for (int i = 0; i < gd; i++) begin
            if (!lock_req || write_data_valid) bad++;
            if (poke && i == 2) begin
                req_valid = 1'b1; req_kind = 2'b11; req_len = 8'd3;
                chk("second request not ready", req_ready, 0);
            end else req_valid = 1'b0;
            tick();
        end
        req_valid = 1'b0;
        chk("lock held before grant", bad, 0);
        lock_res = 1'b1;
        t_g = cyc;
        t_d = -1;
        for (int i = 0; i < 5000 && t_d < 0; i++) begin
            tick();
            if (done) t_d = cyc;
        end
        lock_res = 1'b0;
        bp = 1'b0;
        chk("done seen", t_d >= 0, 1);
        tick();
        chk("req_ready after done", req_ready, 1);
        chk("lock dropped", lock_req, 0);
        bad = 0;
        repeat (3) begin
            tick();
            if (lock_req || done || !req_ready) bad++;
        end
        chk("stays idle", bad, 0);
        chk("done pulses", done_cnt - d0, 1);
        m = 0;
        for (int i = 0; i < exp_b.size() && b0 + i < bytes_q.size(); i++) begin
            m = i;
            if (bytes_q[b0 + i] !== exp_b[i]) break;
        end
        chk("byte count", bytes_q.size() - b0, exp_b.size());
        if (bytes_q.size() > b0) chk("byte value", bytes_q[b0 + m], exp_b[m]);
        m = 0;
        for (int i = 0; i < exp_r.size() && r0 + i < reads_q.size(); i++) begin
            m = i;
            if (reads_q[r0 + i] !== exp_r[i]) break;
        end
        chk("read count", reads_q.size() - r0, exp_r.size());
        if (exp_r.size() > 0 && reads_q.size() > r0) chk("read addr", reads_q[r0 + m], exp_r[m]);
        chk("stall stability", stall_err - s0, 0);
        chk("valid without lock", lock_err - e0, 0);
        if (bytes_q.size() > b0) chk("done timing", t_d, hs_q[$] + 1);
        if (!bpm && bytes_q.size() > b0) chk("header timing", hs_q[b0], t_g + 1);
        if (!bpm && n > 0 && bytes_q.size() > b0 + 1 && rd_q.size() > r0) begin
            chk("read timing", rd_q[r0], hs_q[b0] + 1);
            chk("byte0 timing", hs_q[b0 + 1], hs_q[b0] + 3);
        end
    endtask

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [7:0]  len;
        int          grant;
        bit          bpm;
        bit          poke;
        logic [7:0]  hdr;
        int          nbytes;
    } vec_t;

    initial begin
        vec_t vecs[7];
        int b0, bad;
        vecs[0] = '{2'b00, 32'h1234,     8'd5,   1,  1'b0, 1'b0, 8'h00, 1};
        vecs[1] = '{2'b10, 32'h10,       8'd2,   0,  1'b0, 1'b0, 8'h80, 9};
        vecs[2] = '{2'b10, 32'h10,       8'd2,   0,  1'b1, 1'b0, 8'h80, 9};
        vecs[3] = '{2'b01, 32'h100,      8'd1,   20, 1'b0, 1'b1, 8'h40, 5};
        vecs[4] = '{2'b01, 32'hFFFFFFFF, 8'd2,   0,  1'b0, 1'b0, 8'h40, 9};
        vecs[5] = '{2'b11, 32'h20,       8'd0,   3,  1'b0, 1'b0, 8'hC0, 1};
        vecs[6] = '{2'b10, 32'h1000,     8'd255, 0,  1'b0, 1'b0, 8'h80, 1021};
        repeat (3) @(posedge clock);
        #1;
        chk("reset req_ready", req_ready, 1);
        chk("reset lock_req", lock_req, 0);
        chk("reset mem_read_valid", mem_read_valid, 0);
        chk("reset write_data_valid", write_data_valid, 0);
        chk("reset done", done, 0);
        chk("reset write_data", write_data, 0);
        chk("reset mem_read_addr", mem_read_addr, 0);
        reset = 1'b0;
        tick();
        foreach (vecs[i]) begin
            do_req(vecs[i].kind, vecs[i].addr, vecs[i].len, vecs[i].grant, vecs[i].bpm, vecs[i].poke, b0);
            if (bytes_q.size() > b0) chk($sformatf("vec%0d header", i), bytes_q[b0], vecs[i].hdr);
            chk($sformatf("vec%0d total bytes", i), bytes_q.size() - b0, vecs[i].nbytes);
        end
        for (int i = 0; i < 25; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF - 32'($urandom_range(0, 3)) : $urandom;
            do_req(2'($urandom_range(0, 3)), a, 8'($urandom_range(0, 5)),
                   $urandom_range(0, 4), 1'($urandom_range(0, 1)), 1'b0, b0);
        end
        b0 = bytes_q.size();
        req_valid = 1'b1; req_kind = 2'b10; req_addr = 32'h10; req_len = 8'd2;
        tick();
        req_valid = 1'b0;
        lock_res = 1'b1;
        bad = 0;
        while (bytes_q.size() < b0 + 4 && bad < 100) begin tick(); bad++; end
        chk("bytes before reset", bytes_q.size() - b0, 4);
        if (bytes_q.size() >= b0 + 4) chk("third data byte", bytes_q[b0 + 3], 8'h33);
        reset = 1'b1;
        lock_res = 1'b0;
        tick();
        chk("mid reset lock_req", lock_req, 0);
        chk("mid reset write_data_valid", write_data_valid, 0);
        chk("mid reset done", done, 0);
        chk("mid reset mem_read_valid", mem_read_valid, 0);
        chk("mid reset req_ready", req_ready, 1);
        reset = 1'b0;
        tick();
        do_req(2'b00, 32'h0, 8'd7, 1, 1'b0, 1'b0, b0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end
endmodule
